// File: rtl/pe_net_feeder_pkg.sv
// rtl/pe_net_feeder_pkg.sv - shared sizes, FSM encoding and width helper for the PE array feeder
package pe_net_feeder_pkg;

  localparam int ROW_SIZE = 8;
  localparam int N        = 4;
  localparam int M        = 4;
  localparam int CL_IN    = 4;
  localparam int CL1      = 2;
  localparam int LINES    = 16;
  localparam int KW       = 9;

  // ceil(log2(v)), but never below one bit so a count of 1 still gets a counter
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int KW_W   = clog2_min1(KW);
  localparam int LANE_W = clog2_min1(ROW_SIZE);
  localparam int COL_W  = clog2_min1(LINES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WCONF,
    ST_CCONF,
    ST_STREAM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pe_net_feeder_if.sv
// rtl/pe_net_feeder_if.sv - handshake, config and array-side bus of the PE array feeder
interface pe_net_feeder_if;
  import pe_net_feeder_pkg::*;

  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      w_valid;
  logic                      w_ready;
  logic [ROW_SIZE*M-1:0]     w_data;
  logic [ROW_SIZE*CL_IN-1:0] cfg_d_ch;
  logic [ROW_SIZE*CL_IN-1:0] cfg_bp_ch;
  logic [ROW_SIZE*CL1-1:0]   cfg_bp_src;
  logic                      pix_valid;
  logic                      pix_ready;
  logic [N-1:0]              pix_data;
  logic                      w_conf;
  logic [ROW_SIZE*M-1:0]     w_in;
  logic                      cntl_conf;
  logic [ROW_SIZE*CL_IN-1:0] d_ch_in;
  logic [ROW_SIZE*CL_IN-1:0] bp_ch_in;
  logic [ROW_SIZE*CL1-1:0]   bp_src_in;
  logic [ROW_SIZE*N-1:0]     d_in;
  logic [ROW_SIZE-1:0]       en_in;

  modport master (
    output start, w_valid, w_data, cfg_d_ch, cfg_bp_ch, cfg_bp_src, pix_valid, pix_data,
    input  busy, done, w_ready, pix_ready, w_conf, w_in, cntl_conf,
           d_ch_in, bp_ch_in, bp_src_in, d_in, en_in
  );

  modport slave (
    input  start, w_valid, w_data, cfg_d_ch, cfg_bp_ch, cfg_bp_src, pix_valid, pix_data,
    output busy, done, w_ready, pix_ready, w_conf, w_in, cntl_conf,
           d_ch_in, bp_ch_in, bp_src_in, d_in, en_in
  );

endinterface

// File: rtl/pe_net_col_packer.sv
// rtl/pe_net_col_packer.sv - gathers ROW_SIZE raster pixels into one registered column beat
module pe_net_col_packer
  import pe_net_feeder_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_accept,
  input  logic [N-1:0]          i_pix,
  output logic                  o_col_last,
  output logic [ROW_SIZE*N-1:0] o_d_in,
  output logic [ROW_SIZE-1:0]   o_en_in
);

  logic [LANE_W-1:0]     r_lane;
  logic [ROW_SIZE*N-1:0] r_stage;
  logic [ROW_SIZE*N-1:0] r_d_in;
  logic [ROW_SIZE-1:0]   r_en_in;
  logic                  w_last_lane;
  logic [ROW_SIZE*N-1:0] w_col;

  assign w_last_lane = (r_lane == LANE_W'(ROW_SIZE - 1));
  assign o_col_last  = i_accept && w_last_lane;
  assign o_d_in      = r_d_in;
  assign o_en_in     = r_en_in;

  // the pixel closing a column bypasses the staging register
  always_comb begin
    w_col = r_stage;
    w_col[(ROW_SIZE-1)*N +: N] = i_pix;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lane  <= '0;
      r_stage <= '0;
      r_d_in  <= '0;
      r_en_in <= '0;
    end else begin
      r_en_in <= '0;
      if (i_clr) begin
        r_lane <= '0;
      end else if (i_accept) begin
        r_stage[int'(r_lane)*N +: N] <= i_pix;
        if (w_last_lane) begin
          r_lane  <= '0;
          r_d_in  <= w_col;
          r_en_in <= '1;
        end else begin
          r_lane <= r_lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pe_net_feeder.sv
// rtl/pe_net_feeder.sv - sequences weight load, control load and one pixel frame into the PE array
module pe_net_feeder
  import pe_net_feeder_pkg::*;
(
  input logic       i_clk,
  input logic       i_rst,
  pe_net_feeder_if.slave bus
);

  state_t                    r_state;
  state_t                    w_next;
  logic [KW_W-1:0]           r_wcnt;
  logic [COL_W-1:0]          r_col;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_w_ready;
  logic                      r_pix_ready;
  logic                      r_w_conf;
  logic [ROW_SIZE*M-1:0]     r_w_in;
  logic                      r_cntl_conf;
  logic [ROW_SIZE*CL_IN-1:0] r_cfg_d_ch;
  logic [ROW_SIZE*CL_IN-1:0] r_cfg_bp_ch;
  logic [ROW_SIZE*CL1-1:0]   r_cfg_bp_src;
  logic [ROW_SIZE*CL_IN-1:0] r_d_ch_in;
  logic [ROW_SIZE*CL_IN-1:0] r_bp_ch_in;
  logic [ROW_SIZE*CL1-1:0]   r_bp_src_in;
  logic                      w_start;
  logic                      w_w_acc;
  logic                      w_w_last;
  logic                      w_p_acc;
  logic                      w_col_last;
  logic                      w_frame_last;

  assign w_start      = (r_state == ST_IDLE) && bus.start;
  assign w_w_acc      = bus.w_valid && r_w_ready;
  assign w_w_last     = w_w_acc && (r_wcnt == KW_W'(KW - 1));
  assign w_p_acc      = bus.pix_valid && r_pix_ready;
  assign w_frame_last = w_col_last && (r_col == COL_W'(LINES - 1));

  pe_net_col_packer u_packer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_start),
    .i_accept   (w_p_acc),
    .i_pix      (bus.pix_data),
    .o_col_last (w_col_last),
    .o_d_in     (bus.d_in),
    .o_en_in    (bus.en_in)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (bus.start) w_next = ST_WCONF;
      ST_WCONF:  if (w_w_last) w_next = ST_CCONF;
      ST_CCONF:  w_next = ST_STREAM;
      ST_STREAM: if (w_frame_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // handshake readies lag state entry by one cycle and drop right after the final accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_wcnt       <= '0;
      r_col        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_w_ready    <= 1'b0;
      r_pix_ready  <= 1'b0;
      r_w_conf     <= 1'b0;
      r_w_in       <= '0;
      r_cntl_conf  <= 1'b0;
      r_cfg_d_ch   <= '0;
      r_cfg_bp_ch  <= '0;
      r_cfg_bp_src <= '0;
      r_d_ch_in    <= '0;
      r_bp_ch_in   <= '0;
      r_bp_src_in  <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != ST_IDLE);
      r_done      <= (r_state == ST_DONE);
      r_w_ready   <= (r_state == ST_WCONF) && !w_w_last;
      r_pix_ready <= (r_state == ST_STREAM) && !w_frame_last;
      r_w_conf    <= w_w_acc;
      r_cntl_conf <= (r_state == ST_CCONF);
      if (w_start) begin
        r_cfg_d_ch   <= bus.cfg_d_ch;
        r_cfg_bp_ch  <= bus.cfg_bp_ch;
        r_cfg_bp_src <= bus.cfg_bp_src;
        r_wcnt       <= '0;
        r_col        <= '0;
      end
      if (w_w_acc) begin
        r_w_in <= bus.w_data;
        r_wcnt <= r_wcnt + KW_W'(1);
      end
      if (r_state == ST_CCONF) begin
        r_d_ch_in   <= r_cfg_d_ch;
        r_bp_ch_in  <= r_cfg_bp_ch;
        r_bp_src_in <= r_cfg_bp_src;
      end
      if (w_col_last) r_col <= r_col + COL_W'(1);
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.w_ready   = r_w_ready;
  assign bus.pix_ready = r_pix_ready;
  assign bus.w_conf    = r_w_conf;
  assign bus.w_in      = r_w_in;
  assign bus.cntl_conf = r_cntl_conf;
  assign bus.d_ch_in   = r_d_ch_in;
  assign bus.bp_ch_in  = r_bp_ch_in;
  assign bus.bp_src_in = r_bp_src_in;

endmodule

// File: tb/tb_pe_net_feeder.sv
// tb/tb_pe_net_feeder.sv - randomized frames checked cycle by cycle against a timeline model
module tb_pe_net_feeder;
  import pe_net_feeder_pkg::*;

  localparam int WW   = ROW_SIZE * M;
  localparam int DW   = ROW_SIZE * N;
  localparam int CW   = ROW_SIZE * CL_IN;
  localparam int SW   = ROW_SIZE * CL1;
  localparam int NPIX = LINES * ROW_SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pe_net_feeder_if bus();

  pe_net_feeder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: event timestamps in sample cycles, plus the data each beat must carry
  int t_now = 0;
  int t_start = -1;
  int t_wlast = -1;
  int t_plast = -1;
  bit m_live = 1'b0;
  int m_wcnt = 0;
  int m_pcnt = 0;
  logic          m_wconf_n;
  logic          m_en_n;
  logic [WW-1:0] m_w_in;
  logic [DW-1:0] m_d_in;
  logic [CW-1:0] m_dch, m_bpch, l_dch, l_bpch;
  logic [SW-1:0] m_bpsrc, l_bpsrc;
  logic [N-1:0]  m_col[$];
  logic e_busy, e_wr, e_pr, e_cc, e_done, m_wacc, m_pacc;

  int n_wconf, n_cntl, n_beat, n_done;
  logic [WW-1:0] wlog[$];
  logic [DW-1:0] blog[$];

  always @(negedge clk) begin
    t_now++;
    if (m_live) begin
      e_busy = (t_start >= 0) && (t_now >= t_start + 1) && (t_plast < 0 || t_now <= t_plast + 1);
      e_wr   = (t_start >= 0) && (t_now >= t_start + 2) && (t_wlast < 0);
      e_cc   = (t_wlast >= 0) && (t_now == t_wlast + 2);
      e_pr   = (t_wlast >= 0) && (t_now >= t_wlast + 3) && (t_plast < 0);
      e_done = (t_plast >= 0) && (t_now == t_plast + 2);
      chk("busy",      64'(bus.busy),      64'(e_busy));
      chk("done",      64'(bus.done),      64'(e_done));
      chk("w_ready",   64'(bus.w_ready),   64'(e_wr));
      chk("pix_ready", 64'(bus.pix_ready), 64'(e_pr));
      chk("w_conf",    64'(bus.w_conf),    64'(m_wconf_n));
      chk("w_in",      64'(bus.w_in),      64'(m_w_in));
      chk("cntl_conf", 64'(bus.cntl_conf), 64'(e_cc));
      chk("d_ch_in",   64'(bus.d_ch_in),   64'(m_dch));
      chk("bp_ch_in",  64'(bus.bp_ch_in),  64'(m_bpch));
      chk("bp_src_in", 64'(bus.bp_src_in), 64'(m_bpsrc));
      chk("en_in",     64'(bus.en_in),     m_en_n ? 64'hFF : 64'h0);
      chk("d_in",      64'(bus.d_in),      64'(m_d_in));
      if (bus.w_conf)    begin n_wconf++; wlog.push_back(bus.w_in); end
      if (bus.cntl_conf) n_cntl++;
      if (bus.en_in != '0) begin n_beat++; blog.push_back(bus.d_in); end
      if (bus.done)      n_done++;
    end
    if (rst) begin
      m_live = 1'b1;
      t_start = -1; t_wlast = -1; t_plast = -1;
      m_wcnt = 0; m_pcnt = 0; m_col.delete();
      m_wconf_n = 1'b0; m_en_n = 1'b0;
      m_w_in = '0; m_d_in = '0; m_dch = '0; m_bpch = '0; m_bpsrc = '0;
    end else if (m_live) begin
      if (t_plast >= 0 && t_now == t_plast + 2) begin
        t_start = -1; t_wlast = -1; t_plast = -1;
      end
      if (t_wlast >= 0 && t_now == t_wlast + 1) begin
        m_dch = l_dch; m_bpch = l_bpch; m_bpsrc = l_bpsrc;
      end
      m_wacc = bus.w_valid && (t_start >= 0) && (t_now >= t_start + 2) && (t_wlast < 0);
      m_pacc = bus.pix_valid && (t_wlast >= 0) && (t_now >= t_wlast + 3) && (t_plast < 0);
      m_wconf_n = m_wacc;
      if (m_wacc) begin
        m_w_in = bus.w_data;
        m_wcnt++;
        if (m_wcnt == KW) t_wlast = t_now;
      end
      m_en_n = 1'b0;
      if (m_pacc) begin
        m_col.push_back(bus.pix_data);
        m_pcnt++;
        if (m_col.size() == ROW_SIZE) begin
          for (int k = 0; k < ROW_SIZE; k++) m_d_in[k*N +: N] = m_col[k];
          m_en_n = 1'b1;
          m_col.delete();
        end
        if (m_pcnt == NPIX) t_plast = t_now;
      end
      if (t_start < 0 && bus.start) begin
        t_start = t_now;
        l_dch = bus.cfg_d_ch; l_bpch = bus.cfg_bp_ch; l_bpsrc = bus.cfg_bp_src;
        m_wcnt = 0; m_pcnt = 0; m_col.delete();
      end
    end
  end

  // wmode: 0 ramp weights, 1 ramp with gaps after beats 3 and 7, 2 random
  // pmode: 0 ramp pixels, 1 random data, 2 random data+gaps, 3 ramp+gaps
  task automatic run_frame(input int wmode, input int pmode, input bit poke, input int rst_at);
    logic [WW-1:0] wq [KW];
    logic [N-1:0]  pq [NPIX + 8];
    int wi, pi, wgap;
    bit wa, pa, dn, poked, aborted;
    for (int i = 0; i < KW; i++) wq[i] = (wmode == 2) ? WW'($urandom) : {ROW_SIZE{M'(i + 1)}};
    for (int i = 0; i < NPIX + 8; i++) pq[i] = (pmode == 0 || pmode == 3) ? N'(i) : N'($urandom);
    n_wconf = 0; n_cntl = 0; n_beat = 0; n_done = 0;
    wlog.delete(); blog.delete();
    bus.cfg_d_ch = CW'($urandom); bus.cfg_bp_ch = CW'($urandom); bus.cfg_bp_src = SW'($urandom);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cfg_d_ch = CW'($urandom); bus.cfg_bp_ch = CW'($urandom); bus.cfg_bp_src = SW'($urandom);
    wi = 0; pi = 0; wgap = 0; dn = 1'b0; poked = 1'b0; aborted = 1'b0;
    for (int cyc = 0; cyc < 4000 && !dn; cyc++) begin
      if (rst_at >= 0 && pi == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1'b1;
        dn = 1'b1;
      end else begin
        bus.w_valid   = (wi < KW) && (wgap == 0) && (wmode != 2 || $urandom_range(0, 2) != 0);
        bus.w_data    = wq[(wi < KW) ? wi : KW - 1];
        bus.pix_valid = (pi < NPIX + 8) && (pmode < 2 || $urandom_range(0, 3) != 0);
        bus.pix_data  = pq[(pi < NPIX + 8) ? pi : NPIX + 7];
        bus.start     = poke && ((pi == NPIX && !poked) || (pi < NPIX && $urandom_range(0, 3) == 0));
        if (pi == NPIX) poked = 1'b1;
        @(negedge clk);
        wa = bus.w_valid && bus.w_ready;
        pa = bus.pix_valid && bus.pix_ready;
        dn = bus.done;
        @(posedge clk); #1;
        if (wgap > 0) wgap--;
        if (wa) begin
          wi++;
          if (wmode == 1 && (wi == 3 || wi == 7)) wgap = 2;
        end
        if (pa) pi++;
      end
    end
    bus.w_valid = 1'b0; bus.pix_valid = 1'b0; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (aborted) begin
      chk("after_rst_busy",  64'(bus.busy),  64'd0);
      chk("after_rst_en_in", 64'(n_done),    64'd0);
    end else begin
      chk("frame_done_seen", 64'(dn),        64'd1);
      chk("w_conf_pulses",   64'(n_wconf),   64'(KW));
      chk("cntl_pulses",     64'(n_cntl),    64'd1);
      chk("column_beats",    64'(n_beat),    64'(LINES));
      chk("done_pulses",     64'(n_done),    64'd1);
      chk("weights_taken",   64'(wi),        64'(KW));
      chk("pixels_taken",    64'(pi),        64'(NPIX));
      if (wmode != 2 && wlog.size() == KW) begin
        chk("w_in_first", 64'(wlog[0]),      64'h11111111);
        chk("w_in_last",  64'(wlog[KW - 1]), 64'h99999999);
      end
      if ((pmode == 0 || pmode == 3) && blog.size() == LINES) begin
        chk("beat0",  64'(blog[0]),  64'h76543210);
        chk("beat1",  64'(blog[1]),  64'hFEDCBA98);
        chk("beat15", 64'(blog[15]), 64'hFEDCBA98);
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.w_valid = 1'b0; bus.w_data = '0;
    bus.cfg_d_ch = '0; bus.cfg_bp_ch = '0; bus.cfg_bp_src = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy",  64'(bus.busy),  64'd0);
    chk("reset_en_in", 64'(bus.en_in), 64'd0);
    chk("reset_w_in",  64'(bus.w_in),  64'd0);
    run_frame(0, 0, 1'b0, -1);
    run_frame(1, 1, 1'b0, -1);
    run_frame(0, 3, 1'b0, -1);
    run_frame(2, 2, 1'b1, -1);
    run_frame(0, 2, 1'b0, 5 * ROW_SIZE + 4);
    run_frame(0, 0, 1'b0, -1);
    run_frame(2, 3, 1'b1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_net_feeder.md
Name: pe_net_feeder

Overview:
Upstream sequencer for the PE array. It takes a start pulse, a weight stream, static control vectors and a raster pixel stream. It drives the array's configuration inputs: w_conf/w_in for KW beats, then a one-cycle cntl_conf carrying the d_ch/bp_ch/bp_src vectors. It then packs one frame of pixels, ROW_SIZE per column, into d_in/en_in column beats.

Parameters:
ROW_SIZE, 8, number of array rows (lanes of d_in/en_in/w_in)
N, 4, pixel width
M, 4, weight width
CL_IN, 4, channels per PE (control vector slice width)
CL1, 2, bypass-source slice width
LINES, 16, columns per frame (column beats emitted per frame)
KW, 9, weight beats per configuration

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins config+frame sequence; honoured only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when last column beat has been issued
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat accepted when w_valid&w_ready
w_data  in  ROW_SIZE*M  one weight per row
cfg_d_ch  in  ROW_SIZE*CL_IN  data-channel enables, sampled at start
cfg_bp_ch  in  ROW_SIZE*CL_IN  bypass channel select, sampled at start
cfg_bp_src  in  ROW_SIZE*CL1  bypass source select, sampled at start
pix_valid  in  1  pixel valid
pix_ready  out  1  pixel accepted when pix_valid&pix_ready
pix_data  in  N  pixel; raster order: lane 0..ROW_SIZE-1 of column 0, then column 1, ...
w_conf  out  1  array weight-load strobe
w_in  out  ROW_SIZE*M  array weight bus
cntl_conf  out  1  array control-load strobe
d_ch_in  out  ROW_SIZE*CL_IN  to array
bp_ch_in  out  ROW_SIZE*CL_IN  to array
bp_src_in  out  ROW_SIZE*CL1  to array
d_in  out  ROW_SIZE*N  column beat, lane k at [k*N +: N]
en_in  out  ROW_SIZE  column-beat enable, all ones for one cycle per beat

Behaviour:
- All outputs are registered. Reset values: all outputs 0, state IDLE, counters 0, config vector registers 0.
- FSM states: IDLE, WCONF, CCONF, STREAM, DONE.
- IDLE: start=1 latches cfg_* into registers, clears counters, moves to WCONF. start outside IDLE is ignored with no side effects.
- WCONF: w_ready=1 (registered, asserted the cycle after entry).
  - Each accepted beat drives, next cycle, w_conf=1 and w_in=w_data.
  - A cycle with no accepted beat gives w_conf=0; w_in holds its last value.
  - The weight counter counts accepted beats 0..KW-1. On the KW-th accept, w_ready drops the next cycle and the FSM goes to CCONF.
  - The array therefore sees exactly KW w_conf pulses, stalls allowed between them.
- CCONF: one cycle with cntl_conf=1 and d_ch_in/bp_ch_in/bp_src_in = latched vectors. These outputs hold their values until the next start; only cntl_conf returns to 0. Then go to STREAM.
- STREAM: pix_ready=1.
  - Each accepted pixel is written to staging lane lane_cnt. lane_cnt wraps ROW_SIZE-1→0.
  - On the accept with lane_cnt=ROW_SIZE-1, the next cycle has d_in = completed staging column (current pixel included) and en_in = all ones. Otherwise en_in=0 and d_in holds its value.
  - Gaps in pix_valid only delay beats. The array has no backpressure, so beats issue at most once per ROW_SIZE accepted pixels.
  - col_cnt counts beats 0..LINES-1. On the beat with col_cnt=LINES-1, pix_ready drops the next cycle and the FSM goes to DONE.
  - Never more than LINES*ROW_SIZE pixels are accepted per frame.
- DONE: done=1 for one cycle, then IDLE. busy=0 from IDLE entry.
- Latency: pixel ROW_SIZE-1 of a column accepted at cycle t → en_in high at t+1. Weight accepted at t → w_conf at t+1.
- Counter widths: clog2(KW), clog2(ROW_SIZE), clog2(LINES), each at least 1 bit.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A partial column is discarded. No done is issued.
- Start in the same cycle as DONE is ignored (state is not IDLE).

Decomposition:
- Shared package: FSM state encoding (IDLE/WCONF/CCONF/STREAM/DONE), and a clog2-style function with a min-1 rule.
- Natural sub-module: pe_net_col_packer (staging register, lane counter, column beat output). The FSM and config logic stay in the top.

Test Plan:
- ROW_SIZE=8, KW=9: start, then 9 back-to-back weights 0x11111111..0x99999999 → w_conf high exactly 9 cycles with matching w_in, then cntl_conf high 1 cycle with the latched cfg values.
- Weight stream with 2-cycle gaps after beats 3 and 7 → w_conf pulses still total 9, w_in holds across gaps, CCONF follows the 9th beat.
- LINES=16, pixels 0..127 continuous → 16 en_in=0xFF beats every 8 cycles. Beat c lane k = (8c+k) mod 16. done one cycle after beat 15, busy drops.
- Random pix_valid gaps → identical beat contents and order. pix_ready low outside STREAM; the 129th pixel is not accepted.
- start pulsed during WCONF and STREAM → ignored, sequence unchanged.
- rst asserted after 4 pixels of column 5 → next cycle all outputs 0, IDLE. A fresh start runs a full correct frame with no stale lanes.
